// File: rtl/rf_port_sched.sv
// Shared rs-port scheduler: arbitrates two writeback requesters into an in-order write queue and
// interleaves queue drains with decode reads on the single register-file rs/write port.
module rf_port_sched #(
  parameter int unsigned COUNT = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_valid,
  input  logic [COUNT-2:0]           rd_addr,
  output logic                       rd_ready,
  input  logic                       wa_valid,
  output logic                       wa_ready,
  input  logic [COUNT-2:0]           wa_addr,
  input  logic [DW-1:0]              wa_data,
  input  logic                       wa_cout_en,
  input  logic [DW-1:0]              wa_cout,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [COUNT-2:0]           wb_addr,
  input  logic [DW-1:0]              wb_data,
  output logic [COUNT-2:0]           rf_rs,
  output logic                       rf_we,
  output logic [DW-1:0]              rf_wdata,
  output logic                       rf_cout_we,
  output logic [DW-1:0]              rf_cout_data,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       cout_pending
);

  localparam int unsigned AW = COUNT - 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cout_en;
    logic [DW-1:0] cout;
  } entry_t;

  // Entry 0 is always the head; entries [0, r_cnt) are valid.
  entry_t        r_q [DEPTH];
  logic [CW-1:0] r_cnt;
  logic          r_prefer_b;

  entry_t        w_shift [DEPTH];
  entry_t        w_new;
  logic          w_full;
  logic          w_can_push;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_push;
  logic          w_hazard;
  logic          w_cout_pend;
  logic          w_drain;
  logic [CW-1:0] w_wr_idx;

  assign w_full     = (r_cnt == CW'(DEPTH));
  // Ready looks only at the registered count, so a full queue refuses even when it pops.
  assign w_can_push = rst_n & ~w_full;
  assign w_grant_a  = w_can_push & wa_valid & (~wb_valid | ~r_prefer_b);
  assign w_grant_b  = w_can_push & wb_valid & (~wa_valid | r_prefer_b);
  assign w_push     = w_grant_a | w_grant_b;

  always_comb begin
    w_new = '0;
    if (w_grant_a) begin
      w_new.addr    = wa_addr;
      w_new.data    = wa_data;
      w_new.cout_en = wa_cout_en;
      w_new.cout    = wa_cout;
    end else begin
      w_new.addr    = wb_addr;
      w_new.data    = wb_data;
    end
  end

  always_comb begin
    w_hazard    = 1'b0;
    w_cout_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_cnt) begin
        if (r_q[i].addr == rd_addr) w_hazard = 1'b1;
        if (r_q[i].cout_en)         w_cout_pend = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_shift[i] = r_q[i+1];
    end
    w_shift[DEPTH-1] = r_q[DEPTH-1];
  end

  // Reads win the port unless the queue is full or holds a write to the read address.
  assign w_drain  = rst_n & (r_cnt != '0) & (~rd_valid | w_full | w_hazard);
  assign w_wr_idx = r_cnt - CW'(w_drain);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_prefer_b <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (CW'(i) == w_wr_idx)) begin
          r_q[i] <= w_new;
        end else if (w_drain) begin
          r_q[i] <= w_shift[i];
        end
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_drain);
      if (w_push) r_prefer_b <= w_grant_a;
    end
  end

  assign wa_ready     = w_grant_a;
  assign wb_ready     = w_grant_b;
  assign rd_ready     = rst_n & rd_valid & ~w_drain;
  assign rf_rs        = w_drain ? r_q[0].addr : rd_addr;
  assign rf_we        = w_drain;
  assign rf_wdata     = r_q[0].data;
  assign rf_cout_we   = w_drain & r_q[0].cout_en;
  assign rf_cout_data = r_q[0].cout;
  assign q_count      = r_cnt;
  assign cout_pending = w_cout_pend;

endmodule

// File: tb/tb_rf_port_sched.sv
// Directed bench for rf_port_sched: expected register-file writes are queued at request time and
// checked by an independent monitor; port/handshake behaviour is checked inline per cycle.
module tb_rf_port_sched;

  logic       clk;
  logic       rst_n;
  logic       rd_valid;
  logic [1:0] rd_addr;
  logic       rd_ready;
  logic       wa_valid;
  logic       wa_ready;
  logic [1:0] wa_addr;
  logic [7:0] wa_data;
  logic       wa_cout_en;
  logic [7:0] wa_cout;
  logic       wb_valid;
  logic       wb_ready;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic [1:0] rf_rs;
  logic       rf_we;
  logic [7:0] rf_wdata;
  logic       rf_cout_we;
  logic [7:0] rf_cout_data;
  logic [1:0] q_count;
  logic       cout_pending;

  typedef struct {
    logic [1:0] rs;
    logic [7:0] data;
    logic       cwe;
    logic [7:0] cdata;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  rf_port_sched #(
    .COUNT(3),
    .DW   (8),
    .DEPTH(2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_valid    (rd_valid),
    .rd_addr     (rd_addr),
    .rd_ready    (rd_ready),
    .wa_valid    (wa_valid),
    .wa_ready    (wa_ready),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wa_cout_en  (wa_cout_en),
    .wa_cout     (wa_cout),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rf_rs       (rf_rs),
    .rf_we       (rf_we),
    .rf_wdata    (rf_wdata),
    .rf_cout_we  (rf_cout_we),
    .rf_cout_data(rf_cout_data),
    .q_count     (q_count),
    .cout_pending(cout_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_valid   = 1'b0;
    rd_addr    = '0;
    wa_valid   = 1'b0;
    wa_addr    = '0;
    wa_data    = '0;
    wa_cout_en = 1'b0;
    wa_cout    = '0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
  endtask

  task automatic exp_wr(input logic [1:0] rs, input logic [7:0] d, input logic cwe,
                        input logic [7:0] cd);
    wr_t e;
    e.rs    = rs;
    e.data  = d;
    e.cwe   = cwe;
    e.cdata = cd;
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got rs=%0d data=%0h expected no write", rf_rs, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_rs", 32'(rf_rs), 32'(e.rs));
        chk("wr_data", 32'(rf_wdata), 32'(e.data));
        chk("wr_cout_we", 32'(rf_cout_we), 32'(e.cwe));
        if (e.cwe) chk("wr_cout_data", 32'(rf_cout_data), 32'(e.cdata));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n    = 1'b0;
    wa_valid = 1'b1;
    rd_valid = 1'b1;
    step();
    @(negedge clk);
    chk("rst_qcount", 32'(q_count), 0);
    chk("rst_wa_ready", 32'(wa_ready), 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_we", 32'(rf_we), 0);
    step();
    idle();
    rst_n = 1'b1;

    // Single A write, port idle: written the next cycle.
    wa_valid = 1'b1; wa_addr = 2'd1; wa_data = 8'h5A;
    exp_wr(2'd1, 8'h5A, 1'b0, 8'h00);
    @(negedge clk);
    chk("t1_wa_ready", 32'(wa_ready), 1);
    chk("t1_we_early", 32'(rf_we), 0);
    step();
    wa_valid = 1'b0;
    @(negedge clk);
    chk("t1_qcount", 32'(q_count), 1);
    chk("t1_we", 32'(rf_we), 1);
    step();
    @(negedge clk);
    chk("t1_qcount_end", 32'(q_count), 0);
    chk("t1_we_idle", 32'(rf_we), 0);

    // Fresh pointer, both requesters valid: alternate A,B,A,B.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wa_valid = 1'b1; wa_addr = 2'd2; wa_data = 8'hA0 + 8'(i);
      wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 8'hB0 + 8'(i);
      if (i % 2 == 0) exp_wr(2'd2, 8'hA0 + 8'(i), 1'b0, 8'h00);
      else            exp_wr(2'd3, 8'hB0 + 8'(i), 1'b0, 8'h00);
      @(negedge clk);
      chk("t2_wa_ready", 32'(wa_ready), 32'(i % 2 == 0));
      chk("t2_wb_ready", 32'(wb_ready), 32'(i % 2 == 1));
      step();
    end
    idle();
    @(negedge clk);
    chk("t2_qcount_tail", 32'(q_count), 1);
    chk("t2_we_tail", 32'(rf_we), 1);
    step();
    @(negedge clk);
    chk("t2_qcount_end", 32'(q_count), 0);

    // Read hazards on a queued address: write first, read a cycle later.
    step();
    wa_valid = 1'b1; wa_addr = 2'd2; wa_data = 8'h33;
    exp_wr(2'd2, 8'h33, 1'b0, 8'h00);
    step();
    wa_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 2'd2;
    @(negedge clk);
    chk("t3_rd_ready_stall", 32'(rd_ready), 0);
    chk("t3_we", 32'(rf_we), 1);
    chk("t3_rs_drain", 32'(rf_rs), 2);
    step();
    @(negedge clk);
    chk("t3_rd_ready", 32'(rd_ready), 1);
    chk("t3_rs_read", 32'(rf_rs), 2);
    chk("t3_we_off", 32'(rf_we), 0);
    step();
    idle();

    // Continuous reads to addr0: writes wait until the queue fills.
    rd_valid = 1'b1; rd_addr = 2'd0;
    wa_valid = 1'b1; wa_addr = 2'd3; wa_data = 8'h44;
    exp_wr(2'd3, 8'h44, 1'b0, 8'h00);
    @(negedge clk);
    chk("t4_rd_ready0", 32'(rd_ready), 1);
    chk("t4_qcount0", 32'(q_count), 0);
    step();
    wa_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 8'h55;
    exp_wr(2'd3, 8'h55, 1'b0, 8'h00);
    @(negedge clk);
    chk("t4_rd_ready1", 32'(rd_ready), 1);
    chk("t4_qcount1", 32'(q_count), 1);
    chk("t4_wb_ready", 32'(wb_ready), 1);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t4_qcount_full", 32'(q_count), 2);
    chk("t4_rd_ready_forced", 32'(rd_ready), 0);
    chk("t4_we_forced", 32'(rf_we), 1);
    step();
    @(negedge clk);
    chk("t4_qcount3", 32'(q_count), 1);
    chk("t4_rd_ready3", 32'(rd_ready), 1);
    chk("t4_rs3", 32'(rf_rs), 0);
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("t4_we_last", 32'(rf_we), 1);
    step();
    @(negedge clk);
    chk("t4_qcount_end", 32'(q_count), 0);

    // COUT write travels with its entry.
    step();
    wa_valid = 1'b1; wa_addr = 2'd0; wa_data = 8'h10; wa_cout_en = 1'b1; wa_cout = 8'h01;
    exp_wr(2'd0, 8'h10, 1'b1, 8'h01);
    @(negedge clk);
    chk("t5_cout_pending_pre", 32'(cout_pending), 0);
    step();
    idle();
    @(negedge clk);
    chk("t5_cout_pending", 32'(cout_pending), 1);
    chk("t5_we", 32'(rf_we), 1);
    chk("t5_cout_we", 32'(rf_cout_we), 1);
    chk("t5_cout_data", 32'(rf_cout_data), 32'h01);
    step();
    @(negedge clk);
    chk("t5_cout_pending_post", 32'(cout_pending), 0);
    chk("t5_qcount_end", 32'(q_count), 0);

    // Fill the queue, then reset: queued writes must be discarded.
    step();
    rd_valid = 1'b1; rd_addr = 2'd1;
    wa_valid = 1'b1; wa_addr = 2'd3; wa_data = 8'h66;
    @(negedge clk);
    chk("t6_wa_ready", 32'(wa_ready), 1);
    step();
    wa_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 8'h77;
    @(negedge clk);
    chk("t6_wb_ready", 32'(wb_ready), 1);
    step();
    wb_valid = 1'b0;
    wa_valid = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("t6_qcount_full", 32'(q_count), 2);
    chk("t6_rst_we", 32'(rf_we), 0);
    chk("t6_rst_rd_ready", 32'(rd_ready), 0);
    chk("t6_rst_wa_ready", 32'(wa_ready), 0);
    step();
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_post_qcount", 32'(q_count), 0);
      chk("t6_post_we", 32'(rf_we), 0);
      step();
    end

    chk("pending_writes", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
